// File: rtl/vga_pkg.sv
// Shared VGA constants and types for the rectangle drawing path.
//
// Holds the rectangle geometry and colours used by both draw_rect and the
// rectangle controller, plus the bundled timing-bus type that travels
// through the pipeline alongside the pixel data.
//
// Contents:
//   W_OF_REC, H_OF_REC   default rectangle size in pixels
//   RECT_FILL_RGB        default interior colour (RGB 4:4:4)
//   RECT_BORDER_RGB      ring colour when RECT_BORDER_EN is defined
//   RECT_FLOOR_Y         lowest top-edge row the controller lets the rectangle reach
//   PIPE_DEL             clock latency of draw_rect
//   vga_timing_t         {hcount, hsync, hblnk, vcount, vsync, vblnk}
package vga_pkg;

    localparam int W_OF_REC = 48;
    localparam int H_OF_REC = 64;

    localparam logic [11:0] RECT_FILL_RGB   = 12'hFA0;
    localparam logic [11:0] RECT_BORDER_RGB = 12'h0F0;

    // The controller stops the rectangle so its bottom edge sits on line 600.
    localparam int RECT_FLOOR_Y = 601 - H_OF_REC;

    localparam int PIPE_DEL = 2;

    typedef struct packed {
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
    } vga_timing_t;

endpackage

// File: rtl/vga_delay.sv
// Generic fixed-latency register pipeline.
//
// Delays i_data by CLK_DEL clocks. Every stage clears on the synchronous
// active-high reset, so the output reads zero while reset is held and
// refills over CLK_DEL clocks after it drops.
//
// Parameters:
//   WIDTH    bus width in bits
//   CLK_DEL  number of register stages (must be at least 1)
// Ports:
//   i_clk    clock
//   i_rst    synchronous active-high reset
//   i_data   bus to delay
//   o_data   bus delayed by CLK_DEL clocks
module vga_delay #(
    parameter int WIDTH   = 26,
    parameter int CLK_DEL = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_pipe [CLK_DEL];

    // Shift register: stage 0 takes the input, each later stage takes the one before it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < CLK_DEL; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_data;
            for (int i = 1; i < CLK_DEL; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_data = r_pipe[CLK_DEL-1];

endmodule

// File: rtl/draw_rect.sv
// draw_rect: overlays a solid rectangle on the VGA pixel stream.
//
// The rectangle's top-left corner (xpos, ypos) is captured once per frame on
// the rising edge of vblnk_in so a moving rectangle never tears. Every output
// is registered and delayed exactly 2 clocks from the inputs.
//
// Configuration macro: RECT_BORDER_EN
//   defined   - outermost 1-pixel ring drawn in RECT_BORDER_RGB, interior in RECT_COLOR
//   undefined - whole rectangle drawn in RECT_COLOR, no ring logic
//
// Parameters:
//   RECT_W, RECT_H  rectangle size in pixels (0 in either disables drawing)
//   RECT_COLOR      12-bit fill colour
// Ports:
//   clk, rst                      pixel clock, synchronous active-high reset
//   xpos, ypos      [11:0]        rectangle top-left corner from the controller
//   hcount_in/vcount_in [10:0]    pixel counters
//   hsync_in, hblnk_in, vsync_in, vblnk_in   timing strobes
//   rgb_in          [11:0]        background pixel
//   *_out                         the same signals, 2 clocks later, rgb with rectangle
import vga_pkg::*;

module draw_rect #(
    parameter int          RECT_W     = W_OF_REC,
    parameter int          RECT_H     = H_OF_REC,
    parameter logic [11:0] RECT_COLOR = RECT_FILL_RGB
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic [10:0] hcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [10:0] vcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [10:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam logic [12:0] RECT_W13 = 13'(RECT_W);
    localparam logic [12:0] RECT_H13 = 13'(RECT_H);

    logic [11:0] r_xQ;
    logic [11:0] r_yQ;
    logic        r_vblnkD;

    logic [11:0] r_rgbD1;
    logic        r_inRectD1;
    logic        r_blankD1;
    logic [11:0] r_rgbOut;

    vga_timing_t w_timingIn;
    vga_timing_t w_timingOut;

    logic [12:0] w_hcount13;
    logic [12:0] w_vcount13;
    logic [12:0] w_xEnd;
    logic [12:0] w_yEnd;
    logic        w_inRect;
    logic [11:0] w_rectColor;

    // Capture the controller's position only on the blank rising edge, so the
    // rectangle stays put for the whole visible part of a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vblnkD <= 1'b0;
            r_xQ     <= '0;
            r_yQ     <= '0;
        end else begin
            r_vblnkD <= vblnk_in;
            if (vblnk_in && !r_vblnkD) begin
                r_xQ <= xpos;
                r_yQ <= ypos;
            end
        end
    end

    // Edge sums are 13 bits wide so a rectangle near the right edge of the
    // 12-bit position range cannot wrap around and match small counters.
    assign w_hcount13 = {2'b00, hcount_in};
    assign w_vcount13 = {2'b00, vcount_in};
    assign w_xEnd     = {1'b0, r_xQ} + RECT_W13;
    assign w_yEnd     = {1'b0, r_yQ} + RECT_H13;

    assign w_inRect = (w_hcount13 >= {1'b0, r_xQ}) && (w_hcount13 < w_xEnd) &&
                      (w_vcount13 >= {1'b0, r_yQ}) && (w_vcount13 < w_yEnd);

    // Stage 1: rectangle hit test plus the pixel and blanking state it gates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgbD1    <= '0;
            r_inRectD1 <= 1'b0;
            r_blankD1  <= 1'b0;
        end else begin
            r_rgbD1    <= rgb_in;
            r_inRectD1 <= w_inRect;
            r_blankD1  <= hblnk_in || vblnk_in;
        end
    end

`ifdef RECT_BORDER_EN
    logic r_onRingD1;
    logic w_onRing;

    // Ring test only matters inside the rectangle, which also keeps the
    // "-1" edges harmless for a zero-size rectangle.
    assign w_onRing = w_inRect &&
                      ((w_hcount13 == {1'b0, r_xQ}) || (w_hcount13 == w_xEnd - 13'd1) ||
                       (w_vcount13 == {1'b0, r_yQ}) || (w_vcount13 == w_yEnd - 13'd1));

    // Stage 1 ring flag, aligned with r_inRectD1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_onRingD1 <= 1'b0;
        end else begin
            r_onRingD1 <= w_onRing;
        end
    end

    // Colour of a rectangle pixel: border on the ring, fill elsewhere.
    always_comb begin
        w_rectColor = RECT_COLOR;
        if (r_onRingD1) begin
            w_rectColor = RECT_BORDER_RGB;
        end
    end
`else
    // Whole rectangle in the fill colour.
    always_comb begin
        w_rectColor = RECT_COLOR;
    end
`endif

    // Stage 2: paint the rectangle only in the visible area; blanking passes rgb through.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgbOut <= '0;
        end else if (r_inRectD1 && !r_blankD1) begin
            r_rgbOut <= w_rectColor;
        end else begin
            r_rgbOut <= r_rgbD1;
        end
    end

    assign w_timingIn = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
                          vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in};

    vga_delay #(
        .WIDTH   ($bits(vga_timing_t)),
        .CLK_DEL (PIPE_DEL)
    ) u_timingDelay (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_data (w_timingIn),
        .o_data (w_timingOut)
    );

    assign hcount_out = w_timingOut.hcount;
    assign hsync_out  = w_timingOut.hsync;
    assign hblnk_out  = w_timingOut.hblnk;
    assign vcount_out = w_timingOut.vcount;
    assign vsync_out  = w_timingOut.vsync;
    assign vblnk_out  = w_timingOut.vblnk;
    assign rgb_out    = r_rgbOut;

endmodule

// File: tb/tb_draw_rect.sv
// Testbench for draw_rect with default parameters (48x64 rectangle).
// Expected colours switch on RECT_BORDER_EN to match the build under test.
import vga_pkg::*;

module tb_draw_rect;

    localparam logic [11:0] FILL = RECT_FILL_RGB;
`ifdef RECT_BORDER_EN
    localparam logic [11:0] EDGE = RECT_BORDER_RGB;
`else
    localparam logic [11:0] EDGE = RECT_FILL_RGB;
`endif

    typedef struct {
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic [11:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] xpos, ypos;
    logic [10:0] hcountIn, vcountIn;
    logic        hsyncIn, hblnkIn, vsyncIn, vblnkIn;
    logic [11:0] rgbIn;
    logic [10:0] hcountOut, vcountOut;
    logic        hsyncOut, hblnkOut, vsyncOut, vblnkOut;
    logic [11:0] rgbOut;

    int total = 0;
    int bad   = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    draw_rect dut (
        .clk        (clk),
        .rst        (rst),
        .xpos       (xpos),
        .ypos       (ypos),
        .hcount_in  (hcountIn),
        .hsync_in   (hsyncIn),
        .hblnk_in   (hblnkIn),
        .vcount_in  (vcountIn),
        .vsync_in   (vsyncIn),
        .vblnk_in   (vblnkIn),
        .rgb_in     (rgbIn),
        .hcount_out (hcountOut),
        .hsync_out  (hsyncOut),
        .hblnk_out  (hblnkOut),
        .vcount_out (vcountOut),
        .vsync_out  (vsyncOut),
        .vblnk_out  (vblnkOut),
        .rgb_out    (rgbOut)
    );

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic addVec(input int hc, input int vc, input logic hb, input logic vb,
                          input logic [11:0] rgb, input logic [11:0] exp);
        vec_t v;
        v.hc  = 11'(hc);
        v.vc  = 11'(vc);
        v.hb  = hb;
        v.vb  = vb;
        v.rgb = rgb;
        v.exp = exp;
        vq.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        hcountIn = v.hc;
        vcountIn = v.vc;
        hsyncIn  = v.hc[0];
        vsyncIn  = v.vc[1];
        hblnkIn  = v.hb;
        vblnkIn  = v.vb;
        rgbIn    = v.rgb;
    endtask

    task automatic checkOutput(input string tag, input int idx, input vec_t v);
        check($sformatf("%s[%0d].rgb", tag, idx), 40'(rgbOut), 40'(v.exp));
        check($sformatf("%s[%0d].timing", tag, idx),
              40'({hcountOut, hsyncOut, hblnkOut, vcountOut, vsyncOut, vblnkOut}),
              40'({v.hc, v.hc[0], v.hb, v.vc, v.vc[1], v.vb}));
    endtask

    task automatic checkZero(input string name);
        check(name, 40'({hcountOut, hsyncOut, hblnkOut, vcountOut, vsyncOut, vblnkOut, rgbOut}), 40'd0);
    endtask

    // Streams the queued vectors one per clock and checks each one exactly 2 clocks later.
    task automatic runVectors(input string tag);
        int n;
        n = vq.size();
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            if (i >= 2) checkOutput(tag, i - 2, vq[i-2]);
            if (i < n) applyStimulus(vq[i]);
        end
        vq.delete();
    endtask

    // Produces one vblnk rising edge so the DUT latches (x, y).
    task automatic latchPos(input int x, input int y);
        @(negedge clk);
        xpos     = 12'(x);
        ypos     = 12'(y);
        hblnkIn  = 1'b0;
        vblnkIn  = 1'b1;
        @(negedge clk);
        vblnkIn  = 1'b0;
        @(negedge clk);
    endtask

    // Releases reset with a known vector held, expecting zeros for 1 clock and the vector after 2.
    task automatic releaseCheck(input string tag);
        vec_t v;
        v.hc = 11'd500; v.vc = 11'd500; v.hb = 1'b0; v.vb = 1'b0;
        v.rgb = 12'h5A5; v.exp = 12'h5A5;
        rst = 1'b0;
        applyStimulus(v);
        @(negedge clk);
        checkZero({tag, ".refill1"});
        @(negedge clk);
        checkOutput({tag, ".refill2"}, 0, v);
    endtask

    initial begin
        rst = 1'b1;
        xpos = '0; ypos = '0;
        hcountIn = '0; vcountIn = '0;
        hsyncIn = 1'b0; hblnkIn = 1'b0; vsyncIn = 1'b0; vblnkIn = 1'b0;
        rgbIn = '0;

        // Reset held for 3 clocks with random inputs.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k > 0) checkZero($sformatf("reset%0d", k));
            hcountIn = 11'($urandom); vcountIn = 11'($urandom);
            hsyncIn = 1'($urandom); hblnkIn = 1'($urandom);
            vsyncIn = 1'($urandom); vblnkIn = 1'b0;
            rgbIn = 12'($urandom);
            xpos = 12'($urandom); ypos = 12'($urandom);
        end
        releaseCheck("release");

        // Fill and edges of the rectangle at (100, 200).
        latchPos(100, 200);
        addVec(100, 200, 0, 0, 12'h111, EDGE);
        addVec(147, 220, 0, 0, 12'h112, EDGE);
        addVec(148, 220, 0, 0, 12'h113, 12'h113);
        addVec(99,  220, 0, 0, 12'h114, 12'h114);
        addVec(120, 263, 0, 0, 12'h115, EDGE);
        addVec(120, 264, 0, 0, 12'h116, 12'h116);
        addVec(120, 199, 0, 0, 12'h117, 12'h117);
        addVec(120, 230, 0, 0, 12'h118, FILL);
        addVec(120, 210, 1, 0, 12'h119, 12'h119);
        addVec(120, 210, 0, 1, 12'h11A, 12'h11A);
        runVectors("fill");

        // Position change mid-frame is ignored until the next blank edge.
        @(negedge clk);
        xpos = 12'd300;
        addVec(100, 250, 0, 0, 12'h221, EDGE);
        addVec(147, 263, 0, 0, 12'h222, EDGE);
        addVec(120, 255, 0, 0, 12'h223, FILL);
        addVec(300, 250, 0, 0, 12'h224, 12'h224);
        runVectors("hold");

        latchPos(300, 200);
        addVec(300, 250, 0, 0, 12'h331, EDGE);
        addVec(320, 250, 0, 0, 12'h332, FILL);
        addVec(347, 250, 0, 0, 12'h333, EDGE);
        addVec(348, 250, 0, 0, 12'h334, 12'h334);
        addVec(120, 250, 0, 0, 12'h335, 12'h335);
        runVectors("moved");

        // No wrap-around: a rectangle at x=4090 never reaches hcount 0..10.
        latchPos(4090, 0);
        for (int h = 0; h <= 10; h++) begin
            addVec(h, 0, 0, 0, 12'(12'h440 + h), 12'(12'h440 + h));
        end
        runVectors("nowrap");

        // Ring versus interior pixels.
        latchPos(100, 200);
        addVec(100, 200, 0, 0, 12'h551, EDGE);
        addVec(147, 230, 0, 0, 12'h552, EDGE);
        addVec(101, 201, 0, 0, 12'h553, FILL);
        addVec(146, 262, 0, 0, 12'h554, FILL);
        runVectors("ring");

        // Mid-frame reset clears every output on the next edge, then refills in 2 clocks.
        @(negedge clk);
        hcountIn = 11'd120; vcountIn = 11'd220; hsyncIn = 1'b1; vsyncIn = 1'b1;
        hblnkIn = 1'b0; vblnkIn = 1'b0; rgbIn = 12'h777;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkZero("midReset");
        releaseCheck("midRelease");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
